// File: rtl/ima_adpcm_dec_mc_if.sv
// Stream bundle for the multi-channel IMA ADPCM decoder: code input, state load, PCM output.
// The master side feeds codes and consumes samples; the slave side is the decoder.
interface ima_adpcm_dec_mc_if #(
  parameter int CH_W = 1
);
  logic [3:0]      inPCM;
  logic [CH_W-1:0] inChan;
  logic            inValid;
  logic            inReady;
  logic            inStateLoad;
  logic [CH_W-1:0] inLoadChan;
  logic [15:0]     inPredictSamp;
  logic [6:0]      inStepIndex;
  logic [15:0]     outSamp;
  logic [CH_W-1:0] outChan;
  logic            outValid;
  logic            outReady;

  modport master (
    output inPCM, inChan, inValid, inStateLoad, inLoadChan, inPredictSamp, inStepIndex, outReady,
    input  inReady, outSamp, outChan, outValid
  );

  modport slave (
    input  inPCM, inChan, inValid, inStateLoad, inLoadChan, inPredictSamp, inStepIndex, outReady,
    output inReady, outSamp, outChan, outValid
  );
endinterface

// File: rtl/ima_adpcm_dec_mc.sv
// Multi-channel IMA ADPCM decoder: a code register stage followed by a decode stage that
// updates per-channel predictor/step-index state and drives a backpressured output register.
module ima_adpcm_dec_mc #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int FRAC_W = 3
) (
  input logic               clock,
  input logic               reset,
  ima_adpcm_dec_mc_if.slave bus
);
  localparam int PW    = 16 + FRAC_W;
  localparam int SW    = 18 + FRAC_W;
  localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NSLOT = 2 ** IW;
  localparam logic [6:0] MAX_IDX = 7'd88;
  localparam logic signed [SW-1:0] P_MAX = {{(SW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [SW-1:0] P_MIN = ~P_MAX;

  localparam int STEP_TABLE [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  logic                 s1Valid;
  logic [3:0]           s1Code;
  logic [CH_W-1:0]      s1Chan;
  logic signed [PW-1:0] predictor [NSLOT];
  logic [6:0]           stepIdx [NSLOT];
  logic                 outValidReg;
  logic [15:0]          outSampReg;
  logic [CH_W-1:0]      outChanReg;

  logic                 adv;
  logic                 s1ChanOk;
  logic                 loadOk;
  logic [IW-1:0]        s1Slot;
  logic [IW-1:0]        loadSlot;
  logic signed [PW-1:0] curPred;
  logic signed [PW-1:0] newPred;
  logic signed [PW-1:0] loadPred;
  logic [6:0]           curIdx;
  logic [6:0]           newIdx;
  logic [6:0]           loadIdx;
  logic [SW-1:0]        stepExt;
  logic [SW-1:0]        delta;
  logic signed [SW-1:0] sum;
  logic [7:0]           idxDelta;
  logic [7:0]           idxSum;
  logic [16:0]          rounded;
  logic [15:0]          newSamp;

  assign s1Slot   = s1Chan[IW-1:0];
  assign loadSlot = bus.inLoadChan[IW-1:0];
  assign s1ChanOk = 32'(s1Chan) < NUM_CH;
  assign loadOk   = bus.inStateLoad && (32'(bus.inLoadChan) < NUM_CH);
  assign loadPred = {bus.inPredictSamp, {FRAC_W{1'b0}}};
  assign loadIdx  = (bus.inStepIndex > MAX_IDX) ? MAX_IDX : bus.inStepIndex;

  assign adv          = s1Valid && (!outValidReg || bus.outReady);
  assign bus.inReady  = !s1Valid || adv;
  assign bus.outValid = outValidReg;
  assign bus.outSamp  = outSampReg;
  assign bus.outChan  = outChanReg;

  // Decode stage: the sum carries a guard bit above the largest predictor+delta magnitude
  // so saturation always sees the true result.
  always_comb begin
    curPred = predictor[s1Slot];
    curIdx  = stepIdx[s1Slot];
    stepExt = SW'(STEP_TABLE[curIdx]);
    delta   = stepExt << (FRAC_W - 3);
    if (s1Code[2]) delta = delta + (stepExt << FRAC_W);
    if (s1Code[1]) delta = delta + (stepExt << (FRAC_W - 1));
    if (s1Code[0]) delta = delta + (stepExt << (FRAC_W - 2));

    sum = SW'(curPred);
    if (s1Code[3]) sum = sum - $signed(delta);
    else           sum = sum + $signed(delta);

    if (sum > P_MAX)      newPred = P_MAX[PW-1:0];
    else if (sum < P_MIN) newPred = P_MIN[PW-1:0];
    else                  newPred = sum[PW-1:0];

    rounded = {newPred[PW-1], newPred[PW-1:FRAC_W]} + {16'd0, newPred[FRAC_W-1]};
    if (!rounded[16] && rounded[15])      newSamp = 16'h7FFF;
    else if (rounded[16] && !rounded[15]) newSamp = 16'h8000;
    else                                  newSamp = rounded[15:0];

    idxDelta = s1Code[2] ? ({5'd0, s1Code[1:0], 1'b0} + 8'd2) : 8'hFF;
    idxSum   = {1'b0, curIdx} + idxDelta;
    if (idxSum[7])                  newIdx = 7'd0;
    else if (idxSum[6:0] > MAX_IDX) newIdx = MAX_IDX;
    else                            newIdx = idxSum[6:0];
  end

  // Pipeline and channel state; a state load is written after the decode write-back so it wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid     <= 1'b0;
      s1Code      <= '0;
      s1Chan      <= '0;
      outValidReg <= 1'b0;
      outSampReg  <= '0;
      outChanReg  <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        predictor[i] <= '0;
        stepIdx[i]   <= '0;
      end
    end else begin
      if (bus.inReady) begin
        s1Valid <= bus.inValid;
        if (bus.inValid) begin
          s1Code <= bus.inPCM;
          s1Chan <= bus.inChan;
        end
      end

      if (adv && s1ChanOk) begin
        predictor[s1Slot] <= newPred;
        stepIdx[s1Slot]   <= newIdx;
      end
      if (loadOk) begin
        predictor[loadSlot] <= loadPred;
        stepIdx[loadSlot]   <= loadIdx;
      end

      if (adv) begin
        outValidReg <= s1ChanOk;
        if (s1ChanOk) begin
          outSampReg <= newSamp;
          outChanReg <= s1Chan;
        end
      end else if (bus.outReady) begin
        outValidReg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ima_adpcm_dec_mc.sv
// Scoreboard bench for ima_adpcm_dec_mc: directed cases plus random streams checked
// against an arithmetic model of IMA ADPCM decoding kept per channel.
module tb_ima_adpcm_dec_mc;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;
  localparam int FRAC_W = 3;

  typedef struct {
    int samp;
    int chan;
  } expT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  expT  expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   predM [4];
  int   idxM [4];
  int   readyMode = 0;
  logic readyLevel = 1'b1;

  int stepTbl [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  ima_adpcm_dec_mc_if #(.CH_W(CH_W)) bus ();

  ima_adpcm_dec_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .FRAC_W(FRAC_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      predM[i] = 0;
      idxM[i]  = 0;
    end
  endfunction

  // Reference decode: predictor kept scaled by 2^FRAC_W, output rounded half-up to 16 bits.
  function automatic int modelStep(input int ch, input int code);
    int mag, d, p, idx, o, pMax;
    mag  = code & 7;
    pMax = (1 << (15 + FRAC_W)) - 1;
    d    = (stepTbl[idxM[ch]] * (2 * mag + 1)) << (FRAC_W - 3);
    p    = (code & 8) ? predM[ch] - d : predM[ch] + d;
    if (p > pMax) p = pMax;
    if (p < -pMax - 1) p = -pMax - 1;
    predM[ch] = p;
    idx = idxM[ch] + ((mag < 4) ? -1 : 2 * (mag - 3));
    if (idx < 0) idx = 0;
    if (idx > 88) idx = 88;
    idxM[ch] = idx;
    o = (p + (1 << (FRAC_W - 1))) >>> FRAC_W;
    if (o > 32767) o = 32767;
    if (o < -32768) o = -32768;
    return o;
  endfunction

  function automatic void modelLoad(input int ch, input int pred16, input int idx);
    if (ch < NUM_CH) begin
      predM[ch] = pred16 * (1 << FRAC_W);
      idxM[ch]  = (idx > 88) ? 88 : idx;
    end
  endfunction

  // Scoreboard monitor: whatever is presented must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOutValid", 1, 0);
        end else begin
          checkOutput("outSamp", int'($signed(bus.outSamp)), expQ[0].samp);
          checkOutput("outChan", int'(bus.outChan), expQ[0].chan);
          if (bus.outReady) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    bus.outReady = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      bus.outReady = (readyMode == 1) ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  task automatic applyStimulus(input int ch, input int code, input bit useExp, input int expSamp);
    int  waitCycles = 0;
    bit  accepted = 1'b0;
    int  o;
    bus.inValid = 1'b1;
    bus.inPCM   = 4'(code);
    bus.inChan  = CH_W'(ch);
    while (!accepted && waitCycles < 100) begin
      @(negedge clock);
      accepted = bus.inReady;
      @(posedge clock);
      #1;
      waitCycles++;
    end
    bus.inValid = 1'b0;
    if (!accepted) begin
      checkOutput("inReadyTimeout", 0, 1);
    end else if (ch < NUM_CH) begin
      o = modelStep(ch, code);
      expQ.push_back('{samp: (useExp ? expSamp : o), chan: ch});
    end
  endtask

  task automatic driveLoad(input int ch, input int pred16, input int idx);
    modelLoad(ch, pred16, idx);
    bus.inStateLoad   = 1'b1;
    bus.inLoadChan    = CH_W'(ch);
    bus.inPredictSamp = 16'(pred16);
    bus.inStepIndex   = 7'(idx);
  endtask

  task automatic loadState(input int ch, input int pred16, input int idx);
    driveLoad(ch, pred16, idx);
    @(posedge clock);
    #1;
    bus.inStateLoad = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    bus.inValid = 1'b0;
    bus.inStateLoad = 1'b0;
    expQ.delete();
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain", expQ.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] r16;
    int n;
    bus.inValid = 1'b0;
    bus.inPCM = '0;
    bus.inChan = '0;
    bus.inStateLoad = 1'b0;
    bus.inLoadChan = '0;
    bus.inPredictSamp = '0;
    bus.inStepIndex = '0;

    applyReset();
    @(negedge clock);
    checkOutput("resetOutValid", int'(bus.outValid), 0);
    checkOutput("resetOutSamp", int'(bus.outSamp), 0);
    checkOutput("resetOutChan", int'(bus.outChan), 0);
    checkOutput("resetInReady", int'(bus.inReady), 1);
    @(posedge clock);
    #1;

    applyStimulus(0, 7, 1, 13);
    applyStimulus(0, 7, 1, 43);
    waitDrain();

    applyReset();
    applyStimulus(1, 15, 1, -13);
    applyStimulus(0, 0, 1, 1);
    waitDrain();

    loadState(0, 32752, 88);
    applyStimulus(0, 7, 1, 32767);
    applyStimulus(0, 8, 0, 0);
    loadState(0, -32768, 88);
    applyStimulus(0, 15, 1, -32768);
    waitDrain();

    // Backpressure: outputs held while stalled, inReady drops once S1 is occupied.
    applyReset();
    readyLevel = 1'b0;
    @(posedge clock);
    #1;
    fork
      begin
        applyStimulus(0, int'($urandom_range(0, 15)), 0, 0);
        applyStimulus(1, int'($urandom_range(0, 15)), 0, 0);
        applyStimulus(0, int'($urandom_range(0, 15)), 0, 0);
        applyStimulus(1, int'($urandom_range(0, 15)), 0, 0);
      end
      begin
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (!bus.outValid && n < 20);
        checkOutput("stallOutValid", int'(bus.outValid), 1);
        @(negedge clock);
        checkOutput("stallInReady", int'(bus.inReady), 0);
        @(negedge clock);
        readyLevel = 1'b1;
      end
    join
    waitDrain();

    applyReset();
    applyStimulus(0, 7, 1, 13);
    driveLoad(0, 1000, 100);
    applyStimulus(0, 3, 1, 29671);
    bus.inStateLoad = 1'b0;
    waitDrain();

    applyReset();
    applyStimulus(3, 7, 0, 0);
    repeat (3) begin
      @(negedge clock);
      checkOutput("dropOutValid", int'(bus.outValid), 0);
    end
    @(posedge clock);
    #1;
    loadState(3, 5000, 40);
    applyStimulus(0, 7, 1, 13);
    applyStimulus(1, 7, 1, 13);
    applyStimulus(0, 0, 0, 0);
    waitDrain();

    // Reset with an output held and a code pending in S1.
    readyLevel = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus(0, 7, 1, 13);
    applyStimulus(0, 1, 0, 0);
    reset = 1'b1;
    expQ.delete();
    modelReset();
    @(posedge clock);
    @(negedge clock);
    checkOutput("midResetOutValid", int'(bus.outValid), 0);
    checkOutput("midResetOutSamp", int'(bus.outSamp), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    readyLevel = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checkOutput("postResetOutValid", int'(bus.outValid), 0);
    end
    @(posedge clock);
    #1;
    applyStimulus(0, 7, 1, 13);
    waitDrain();

    applyReset();
    readyMode = 1;
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 0, 0);
    end
    readyMode = 0;
    readyLevel = 1'b1;
    waitDrain();

    repeat (200) begin
      n = int'($urandom_range(0, 9));
      r16 = 16'($urandom);
      if (n == 0) begin
        loadState(int'($urandom_range(0, 3)), int'($signed(r16)), int'($urandom_range(0, 127)));
      end else if (n == 1) begin
        driveLoad(int'($urandom_range(0, 3)), int'($signed(r16)), int'($urandom_range(0, 127)));
        applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 0, 0);
        bus.inStateLoad = 1'b0;
      end else begin
        applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 0, 0);
      end
    end
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
